bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, BRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 2, BRAM word width.
REQ-003 SHALL have port CLK  in  1  single clock for all logic.
REQ-004 SHALL have port RSTN  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port START  in  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port BASE  in  ADDR_W  first word address, captured on accepted START.
REQ-007 SHALL have port LEN  in  ADDR_W+1  word count, 0..2^ADDR_W, captured on accepted START.
REQ-008 SHALL have port BUSY  out  1  high from accepted START until DONE inclusive.
REQ-009 SHALL have port DONE  out  1  one-cycle pulse at burst completion.
REQ-010 SHALL have port A0  out  ADDR_W  BRAM port address.
REQ-011 SHALL have port CE0  out  1  BRAM port enable, one read per high cycle.
REQ-012 SHALL have port WE0  out  1  constant 0; D0  out  DATA_W  constant 0; WEM0  out  DATA_W  constant 0.
REQ-013 SHALL have port Q0  in  DATA_W  BRAM read data, valid exactly one cycle after CE0.
REQ-014 SHALL have port OUT_VALID  out  1  stream data valid.
REQ-015 SHALL have port OUT_READY  in  1  consumer accept; transfer when OUT_VALID and OUT_READY.
REQ-016 SHALL have port OUT_DATA  out  DATA_W  stream data, stable while OUT_VALID and not OUT_READY.

Function
REQ-017 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-018 IDLE: START=1 SHALL capture BASE/LEN, go to READ (LEN>0) or pulse DONE next cycle and stay IDLE (LEN=0, no CE0).
REQ-019 READ: CE0 SHALL assert only when skid occupancy plus in-flight reads is below 2.
REQ-020 Read k (k=0..LEN-1) SHALL use A0 = (BASE+k) mod 2^ADDR_W; wrap past 2^ADDR_W-1 to 0 required.
REQ-021 Exactly LEN reads SHALL issue; after the last, FSM SHALL go to DRAIN.
REQ-022 Q0 SHALL be written into a 2-entry skid buffer the cycle after each CE0; no word dropped or duplicated under any OUT_READY pattern.
REQ-023 With OUT_READY held 1, throughput SHALL be one word per cycle; first OUT_VALID two cycles after START.
REQ-024 Words SHALL appear on OUT_DATA in address order.
REQ-025 DRAIN: when the final word transfers, DONE SHALL pulse the following cycle and FSM SHALL return to IDLE.
REQ-026 START while BUSY SHALL be ignored.
REQ-027 START in the DONE-pulse cycle SHALL be accepted (back-to-back bursts).

Reset
REQ-028 RSTN low SHALL immediately force IDLE, BUSY=0, DONE=0, CE0=0, A0=0, OUT_VALID=0, OUT_DATA=0, skid empty.
REQ-029 Reset mid-burst SHALL discard pending words; no DONE after release.

Configuration
REQ-030 Macro BRAM_STREAM_READER_ABORT_EN SHALL, when defined, add port ABORT  in  1.
REQ-031 With it: ABORT in READ/DRAIN SHALL stop CE0 that cycle, flush skid and in-flight word, drop OUT_VALID next cycle, return to IDLE without DONE; ABORT in IDLE ignored.
REQ-032 Without it: no ABORT port; bursts always run to completion.

Structure
REQ-033 Shared package bram_stream_pkg SHALL hold the FSM state enum and default ADDR_W/DATA_W constants.
REQ-034 Sub-module bram_rd_skid SHALL implement the 2-entry valid/ready skid buffer.

Verification
REQ-035 BASE=0x010, LEN=4, OUT_READY=1 -> A0 0x010..0x013 on 4 consecutive CE0 cycles, 4 words in order, DONE once.
REQ-036 BASE=0x1FFE, LEN=4 -> A0 sequence 0x1FFE,0x1FFF,0x0000,0x0001.
REQ-037 LEN=8, OUT_READY toggling 1,0,0,1 repeating -> 8 words exactly once in order, OUT_DATA stable while stalled, never more than 2 unread words outstanding.
REQ-038 LEN=0 -> no CE0, DONE one cycle after START; START during BUSY -> no effect.
REQ-039 RSTN low at 3rd word of LEN=6 burst -> all outputs 0 immediately, no DONE; new START after release runs normally.
REQ-040 With BRAM_STREAM_READER_ABORT_EN, ABORT after 2 of 8 words -> CE0 stops that cycle, OUT_VALID low next cycle, no DONE, IDLE.

Source files
------------

// File: rtl/bram_stream_pkg.sv
// Shared types and default widths for the BRAM stream reader and its skid buffer.
// No logic, so there is no latency and no backpressure.
package bram_stream_pkg;
    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;
endpackage

// File: rtl/bram_rd_skid.sv
// 2-entry valid/ready skid for BRAM read data. When empty it passes the input straight through (0 cycles).
// Words are held while o_out_rdy is low. The caller keeps held + incoming at 2 or fewer.
module bram_rd_skid #(
    parameter int DATA_W = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_in_vld,
    input  logic [DATA_W-1:0] i_in_dat,
    output logic              o_out_vld,
    input  logic              i_out_rdy,
    output logic [DATA_W-1:0] o_out_dat,
    output logic [1:0]        o_cnt
);
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [1:0]        r_cnt;
    logic              w_pop;

    assign o_out_vld = (r_cnt != 2'd0) || i_in_vld;
    assign o_out_dat = (r_cnt != 2'd0) ? r_head : (i_in_vld ? i_in_dat : r_head);
    assign o_cnt     = r_cnt;
    assign w_pop     = o_out_vld && i_out_rdy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else if (i_flush) begin
            r_cnt <= 2'd0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    // An incoming word that is accepted immediately bypasses storage.
                    if (i_in_vld && !w_pop) begin
                        r_head <= i_in_dat;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_in_vld && w_pop) begin
                        r_head <= i_in_dat;
                    end else if (i_in_vld) begin
                        r_tail <= i_in_dat;
                        r_cnt  <= 2'd2;
                    end else if (w_pop) begin
                        r_cnt <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (i_in_vld) r_tail <= i_in_dat;
                        else          r_cnt  <= 2'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/bram_stream_reader.sv
// Streams LEN BRAM words from BASE (wrapping) into a valid/ready port. First OUT_VALID comes 2 clocks after START; 1 word/clk when unstalled.
// Reads are throttled so that buffered plus in-flight words never exceed 2. Defining BRAM_STREAM_READER_ABORT_EN adds an ABORT input.
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE,
    input  logic [ADDR_W:0]   LEN,
`ifdef BRAM_STREAM_READER_ABORT_EN
    input  logic              ABORT,
`endif
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] A0,
    output logic              CE0,
    output logic              WE0,
    output logic [DATA_W-1:0] D0,
    output logic [DATA_W-1:0] WEM0,
    input  logic [DATA_W-1:0] Q0,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA
);
    rd_state_e         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remain;
    logic              r_pend;
    logic              r_busy;
    logic              r_done;

    logic              w_abort;
    logic              w_flush;
    logic [1:0]        w_cnt;
    logic [2:0]        w_held;
    logic              w_ce0;
    logic              w_pop;
    logic              w_last_xfer;

`ifdef BRAM_STREAM_READER_ABORT_EN
    assign w_abort = ABORT;
`else
    assign w_abort = 1'b0;
`endif

    // r_pend marks the word the BRAM returns this cycle, which the skid has not yet absorbed.
    assign w_held      = {1'b0, w_cnt} + {2'b00, r_pend};
    assign w_ce0       = (r_state == ST_READ) && !w_abort && (w_held < 3'd2);
    assign w_pop       = OUT_VALID && OUT_READY;
    assign w_flush     = w_abort && (r_state != ST_IDLE);
    assign w_last_xfer = (r_state == ST_DRAIN) && w_pop && (w_held == 3'd1);

    assign BUSY = r_busy;
    assign DONE = r_done;
    assign A0   = r_addr;
    assign CE0  = w_ce0;
    assign WE0  = 1'b0;
    assign D0   = '0;
    assign WEM0 = '0;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_pend   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_pend <= w_ce0;
            case (r_state)
                ST_IDLE: begin
                    // BUSY holds through the DONE cycle, then follows START.
                    r_busy <= START;
                    if (START) begin
                        r_addr   <= BASE;
                        r_remain <= LEN;
                        if (LEN == '0) r_done  <= 1'b1;
                        else           r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_ce0) begin
                        r_addr   <= r_addr + ADDR_W'(1);
                        r_remain <= r_remain - (ADDR_W + 1)'(1);
                        if (r_remain == (ADDR_W + 1)'(1)) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_last_xfer) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    bram_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .i_clk     (CLK),
        .i_rst_n   (RSTN),
        .i_flush   (w_flush),
        .i_in_vld  (r_pend),
        .i_in_dat  (Q0),
        .o_out_vld (OUT_VALID),
        .i_out_rdy (OUT_READY),
        .o_out_dat (OUT_DATA),
        .o_cnt     (w_cnt)
    );
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural 1-cycle BRAM.
// Uses 8-bit data so that the order of the streamed words is observable.
module tb_bram_stream_reader;
    localparam int AW = 13;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          START = 1'b0;
    logic [AW-1:0] BASE = '0;
    logic [AW:0]   LEN = '0;
    logic          BUSY, DONE, CE0, WE0, OUT_VALID;
    logic          OUT_READY = 1'b1;
    logic [AW-1:0] A0;
    logic [DW-1:0] D0, WEM0, Q0, OUT_DATA;
`ifdef BRAM_STREAM_READER_ABORT_EN
    logic          ABORT = 1'b0;
`endif

    bram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .BASE(BASE), .LEN(LEN),
`ifdef BRAM_STREAM_READER_ABORT_EN
        .ABORT(ABORT),
`endif
        .BUSY(BUSY), .DONE(DONE), .A0(A0), .CE0(CE0), .WE0(WE0), .D0(D0), .WEM0(WEM0),
        .Q0(Q0), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] mem_f(input logic [AW-1:0] a);
        return a[7:0] ^ {a[12:8], 3'b000} ^ 8'h3C;
    endfunction

    // Q0 is meaningful only in the cycle after CE0; otherwise it carries junk.
    always @(posedge CLK) Q0 <= CE0 ? mem_f(A0) : 8'hEE;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    logic [AW-1:0] ce_addr[$];
    logic [DW-1:0] outw[$];
    int cyc_n, first_ce, last_ce, first_vld, last_done, done_n, busy_n, ce_seen, xfer_n;
    bit stall_prev, rdy_toggle;
    int rdy_idx;
    logic [DW-1:0] prev_dat;
    logic [3:0] rdy_pat = 4'b1001;

    task automatic clr_logs();
        ce_addr.delete();
        outw.delete();
        cyc_n = 0; first_ce = -1; last_ce = -1; first_vld = -1; last_done = -1;
        done_n = 0; busy_n = 0; ce_seen = 0; xfer_n = 0; stall_prev = 0;
    endtask

    // Called at a negedge with this cycle's inputs already set; samples, then advances one clock.
    task automatic cyc();
        if (rdy_toggle) begin
            OUT_READY = rdy_pat[rdy_idx % 4];
            rdy_idx++;
        end
        #1;
        if (stall_prev) begin
            chk("stall_vld", {31'd0, OUT_VALID}, 32'd1);
            chk("stall_dat", {24'd0, OUT_DATA}, {24'd0, prev_dat});
        end
        chk("unread_le2", {31'd0, (ce_seen - xfer_n) <= 2}, 32'd1);
        chk("vld_model", {31'd0, OUT_VALID}, {31'd0, (ce_seen - xfer_n) > 0});
        if (CE0) begin
            ce_addr.push_back(A0);
            if (first_ce < 0) first_ce = cyc_n;
            last_ce = cyc_n;
        end
        if (DONE) begin done_n++; last_done = cyc_n; end
        if (BUSY) busy_n++;
        if (OUT_VALID && first_vld < 0) first_vld = cyc_n;
        if (OUT_VALID && OUT_READY) begin outw.push_back(OUT_DATA); xfer_n++; end
        stall_prev = OUT_VALID && !OUT_READY;
        prev_dat = OUT_DATA;
        if (CE0) ce_seen++;
        @(negedge CLK);
        cyc_n++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] wrap_seq[4];
        wrap_seq[0] = 13'h1FFE; wrap_seq[1] = 13'h1FFF; wrap_seq[2] = 13'h0000; wrap_seq[3] = 13'h0001;
        rdy_toggle = 0; rdy_idx = 0;
        clr_logs();

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_busy", {31'd0, BUSY}, 0);
        chk("rst_done", {31'd0, DONE}, 0);
        chk("rst_ce0", {31'd0, CE0}, 0);
        chk("rst_a0", {19'd0, A0}, 0);
        chk("rst_vld", {31'd0, OUT_VALID}, 0);
        chk("rst_dat", {24'd0, OUT_DATA}, 0);
        chk("we0_zero", {31'd0, WE0}, 0);
        chk("d0_wem0_zero", {16'd0, D0, WEM0}, 0);
        RSTN = 1'b1;
        @(negedge CLK);

        // Burst at 0x010, LEN 4, consumer always ready
        clr_logs();
        BASE = 13'h010; LEN = 14'd4; START = 1'b1;
        cyc();
        START = 1'b0;
        repeat (5) cyc();
        // DONE cycle: start the wrap burst back-to-back
        BASE = 13'h1FFE; LEN = 14'd4; START = 1'b1;
        cyc();
        START = 1'b0;
        chk("t1_nce", ce_addr.size(), 4);
        for (int k = 0; k < 4; k++) chk("t1_addr", {19'd0, ce_addr[k]}, 32'h10 + k);
        chk("t1_first_ce", first_ce, 1);
        chk("t1_last_ce", last_ce, 4);
        chk("t1_first_vld", first_vld, 2);
        chk("t1_nout", outw.size(), 4);
        for (int k = 0; k < 4; k++) chk("t1_word", {24'd0, outw[k]}, {24'd0, mem_f(AW'(13'h010 + k))});
        chk("t1_ndone", done_n, 1);
        chk("t1_done_cyc", last_done, 6);
        chk("t1_busy_cycles", busy_n, 6);

        // Wrap burst, already accepted in the previous DONE cycle
        clr_logs();
        cyc_n = 1;
        repeat (6) cyc();
        chk("t2_nce", ce_addr.size(), 4);
        for (int k = 0; k < 4; k++) chk("t2_addr", {19'd0, ce_addr[k]}, {19'd0, wrap_seq[k]});
        chk("t2_first_ce", first_ce, 1);
        chk("t2_nout", outw.size(), 4);
        for (int k = 0; k < 4; k++) chk("t2_word", {24'd0, outw[k]}, {24'd0, mem_f(wrap_seq[k])});
        chk("t2_done_cyc", last_done, 6);
        cyc();
        chk("t2_idle_busy", {31'd0, BUSY}, 0);
        chk("t2_ndone", done_n, 1);

        // LEN 8 with stalling consumer; START issued mid-burst must be ignored
        clr_logs();
        rdy_toggle = 1; rdy_idx = 0;
        BASE = 13'h100; LEN = 14'd8; START = 1'b1;
        cyc();
        START = 1'b0;
        BASE = 13'h555; LEN = 14'd3;
        for (int i = 0; i < 80 && done_n == 0; i++) begin
            START = (i == 3);
            cyc();
        end
        START = 1'b0;
        rdy_toggle = 0; OUT_READY = 1'b1;
        repeat (4) cyc();
        chk("t3_ndone", done_n, 1);
        chk("t3_nce", ce_addr.size(), 8);
        for (int k = 0; k < 8; k++) chk("t3_addr", {19'd0, ce_addr[k]}, 32'h100 + k);
        chk("t3_nout", outw.size(), 8);
        for (int k = 0; k < 8; k++) chk("t3_word", {24'd0, outw[k]}, {24'd0, mem_f(AW'(13'h100 + k))});

        // LEN 0: no reads, DONE one cycle after START
        clr_logs();
        BASE = 13'h042; LEN = 14'd0; START = 1'b1;
        cyc();
        START = 1'b0;
        repeat (3) cyc();
        chk("t4_nce", ce_addr.size(), 0);
        chk("t4_ndone", done_n, 1);
        chk("t4_done_cyc", last_done, 1);
        chk("t4_busy_cycles", busy_n, 1);

        // Reset while the 3rd word of a LEN 6 burst is presented
        clr_logs();
        BASE = 13'h200; LEN = 14'd6; START = 1'b1;
        cyc();
        START = 1'b0;
        repeat (3) cyc();
        #1;
        chk("t5_w3_vld", {31'd0, OUT_VALID}, 1);
        chk("t5_w3_dat", {24'd0, OUT_DATA}, {24'd0, mem_f(13'h202)});
        RSTN = 1'b0;
        #1;
        chk("t5_rst_busy", {31'd0, BUSY}, 0);
        chk("t5_rst_done", {31'd0, DONE}, 0);
        chk("t5_rst_ce0", {31'd0, CE0}, 0);
        chk("t5_rst_a0", {19'd0, A0}, 0);
        chk("t5_rst_vld", {31'd0, OUT_VALID}, 0);
        chk("t5_rst_dat", {24'd0, OUT_DATA}, 0);
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        clr_logs();
        repeat (4) cyc();
        chk("t5_no_done", done_n, 0);
        chk("t5_no_ce", ce_addr.size(), 0);
        clr_logs();
        BASE = 13'h300; LEN = 14'd2; START = 1'b1;
        cyc();
        START = 1'b0;
        repeat (5) cyc();
        chk("t5_new_nce", ce_addr.size(), 2);
        chk("t5_new_a1", {19'd0, ce_addr[1]}, 32'h301);
        chk("t5_new_nout", outw.size(), 2);
        chk("t5_new_w0", {24'd0, outw[0]}, {24'd0, mem_f(13'h300)});
        chk("t5_new_w1", {24'd0, outw[1]}, {24'd0, mem_f(13'h301)});
        chk("t5_new_done", done_n, 1);

`ifdef BRAM_STREAM_READER_ABORT_EN
        // Abort after two of eight words have been taken
        clr_logs();
        BASE = 13'h400; LEN = 14'd8; START = 1'b1;
        cyc();
        START = 1'b0;
        repeat (3) cyc();
        chk("t6_pre_nout", outw.size(), 2);
        ABORT = 1'b1;
        cyc();
        ABORT = 1'b0;
        chk("t6_ce_stopped", ce_addr.size(), 3);
        chk("t6_w0", {24'd0, outw[0]}, {24'd0, mem_f(13'h400)});
        chk("t6_w1", {24'd0, outw[1]}, {24'd0, mem_f(13'h401)});
        clr_logs();
        #1;
        chk("t6_vld_low", {31'd0, OUT_VALID}, 0);
        chk("t6_busy_low", {31'd0, BUSY}, 0);
        repeat (4) cyc();
        chk("t6_no_done", done_n, 0);
        chk("t6_no_ce", ce_addr.size(), 0);
        ABORT = 1'b1;
        cyc();
        ABORT = 1'b0;
        BASE = 13'h010; LEN = 14'd1; START = 1'b1;
        cyc();
        START = 1'b0;
        repeat (4) cyc();
        chk("t6_idle_abort_ok", done_n, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
